// File: rtl/disp_word_gen.sv
// Display word generator: converts an 8-bit value to a 3-digit BCD or raw hex
// nibble word for the 7-segment scanner, and produces the scanner's digit clken.
module disp_word_gen #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    input  logic        hex_mode,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] word,
    output logic        clken
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int unsigned    PW    = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);

    logic [1:0]    state;
    logic [7:0]    bin;
    logic [11:0]   bcd;
    logic [11:0]   bcd_adj;
    logic          hex_q;
    logic [2:0]    cnt;
    logic [PW-1:0] presc;

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bin   <= '0;
            bcd   <= '0;
            hex_q <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            word  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin   <= value;
                        hex_q <= hex_mode;
                        bcd   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Hex requests spend one idle cycle here so word lands two edges after start.
                    if (hex_q) begin
                        state <= DONE;
                    end else begin
                        {bcd, bin} <= {bcd_adj, bin} << 1;
                        cnt        <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    word  <= hex_q ? {8'h00, bin} : {4'h0, bcd};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Scan prescaler runs regardless of conversion activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            clken <= 1'b0;
        end else begin
            clken <= (presc == PLAST);
            presc <= (presc == PLAST) ? '0 : presc + PW'(1);
        end
    end

endmodule

// File: tb/tb_disp_word_gen.sv
// Scoreboard bench for disp_word_gen: stimulus pushes expected words, a monitor
// pops them on every done pulse; a second monitor models the clken cadence.
module tb_disp_word_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  value;
    logic        hex_mode;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] word;
    logic        clken;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];
    logic [15:0] mon_exp;
    logic        rst_s;
    int          edges = 0;
    bit          seen_rst = 0;
    int          n;

    logic [7:0]  cv[7] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd128, 8'd255};
    logic [15:0] ce[7] = '{16'h0000, 16'h0009, 16'h0010, 16'h0099, 16'h0100, 16'h0128, 16'h0255};

    always #5 clk = ~clk;

    disp_word_gen #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .hex_mode (hex_mode),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .word     (word),
        .clken    (clken)
    );

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] bcd_ref(input int v);
        return {4'h0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [7:0] v, input logic h, input logic [15:0] exp, input int lat);
        int cycles;
        int bc;
        value    = v;
        hex_mode = h;
        start    = 1'b1;
        sb.push_back(exp);
        tick;
        start    = 1'b0;
        value    = ~v;
        hex_mode = ~h;
        cycles   = 0;
        bc       = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && cycles < 30) begin
            tick;
            cycles++;
            if (busy === 1'b1) bc++;
        end
        check_int("latency", cycles, lat);
        check_int("busy_cycles", bc, lat);
        tick;
        check_int("done_width", int'(done), 0);
        check16("word_hold", word, exp);
    endtask

    // Word scoreboard monitor
    always @(posedge clk) begin
        #2;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%h required=none", word);
            end else begin
                mon_exp = sb.pop_front();
                check16("sb_word", word, mon_exp);
            end
        end
    end

    // clken model: pulse after every 4th edge since reset was last sampled high
    always @(posedge clk) begin
        rst_s = reset;
        #2;
        if (rst_s === 1'b1) begin
            seen_rst = 1;
            edges    = 0;
            check_int("clken_reset", int'(clken), 0);
        end else if (seen_rst) begin
            edges++;
            check_int("clken", int'(clken), (edges % 4 == 0) ? 1 : 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        value    = '0;
        hex_mode = 1'b0;
        repeat (3) tick;
        check16("rst_word", word, 16'h0000);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_int("rst_clken", int'(clken), 0);
        reset = 1'b0;

        convert(8'd255, 1'b0, 16'h0255, 9);
        for (int i = 0; i < 7; i++) convert(cv[i], 1'b0, ce[i], 9);
        convert(8'hA7, 1'b1, 16'h00A7, 2);
        convert(8'hFF, 1'b1, 16'h00FF, 2);

        // start held through a conversion, then relaunched from the done cycle
        value    = 8'd37;
        hex_mode = 1'b0;
        start    = 1'b1;
        sb.push_back(16'h0037);
        tick;
        value = 8'd99;
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            tick;
            n++;
        end
        check_int("held_latency", n, 9);
        value = 8'd42;
        sb.push_back(16'h0042);
        tick;
        start = 1'b0;
        check_int("relaunch_busy", int'(busy), 1);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            tick;
            n++;
        end
        check_int("relaunch_latency", n, 9);
        tick;

        // reset four edges into a conversion of 200
        value = 8'd200;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check16("abort_word", word, 16'h0000);
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_done", int'(done), 0);
        repeat (12) tick;
        check_int("abort_idle", int'(busy), 0);
        convert(8'd200, 1'b0, 16'h0200, 9);

        for (int v = 0; v < 256; v++) convert(8'(v), 1'b0, bcd_ref(v), 9);

        tick;
        tick;
        check_int("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
